// File: rtl/cpu_pkg.sv
// cpu_pkg: opcodes and state encodings shared by the CPU pipeline stages.
package cpu_pkg;

    localparam logic [4:0] OP_LD  = 5'b01001;
    localparam logic [4:0] OP_ST  = 5'b01010;
    localparam logic [4:0] OP_WB0 = 5'b00110;
    localparam logic [4:0] OP_WB1 = 5'b00100;
    localparam logic [4:0] OP_WB2 = 5'b10010;

    typedef enum logic [1:0] {MA_IDLE, MA_LO, MA_HI, MA_DONE} ma_state_e;

    function automatic logic is_memop(input logic [4:0] op);
        return op == OP_LD || op == OP_ST;
    endfunction

endpackage

// File: rtl/mem_access_if.sv
// mem_access_if: 8-bit external memory bus with a per-byte ready handshake.
interface mem_access_if;

    logic        mem_req;
    logic        mem_rd;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [7:0]  mem_dout;
    logic        mem_rdy;
    logic [7:0]  mem_din;

    modport master (output mem_req, mem_rd, mem_wr, mem_addr, mem_dout, input mem_rdy, mem_din);
    modport slave  (input mem_req, mem_rd, mem_wr, mem_addr, mem_dout, output mem_rdy, mem_din);

endinterface

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: counts unready bus cycles of one beat; expired flags the last allowed wait.
module mem_wait_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int W = $clog2(TIMEOUT + 1);

    logic [W-1:0] cnt_q, cnt_d;

    assign cnt_d   = clr ? '0 : en ? cnt_q + 1'b1 : cnt_q;
    // High in the wait cycle whose increment makes the count reach TIMEOUT
    assign expired = en && cnt_q == W'(TIMEOUT - 1);

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/mem_access.sv
// mem_access: t2 memory stage; runs LD/ST as two little-endian byte beats, stalling until done.
module mem_access
    import cpu_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               t2,
    input  logic [15:0]        ir,
    input  logic [15:0]        alu_out,
    input  logic [15:0]        rb_data,
    mem_access_if.master       bus,
    output logic [15:0]        mdr,
    output logic               stall,
    output logic               done,
    output logic               err
);

    ma_state_e   state_q, state_d;
    logic [15:0] base_q, base_d;
    logic [15:0] st_q, st_d;
    logic        is_ld_q, is_ld_d;
    logic [7:0]  lo_q, lo_d;
    logic [15:0] mdr_q, mdr_d;
    logic        to_q, to_d;
    logic        start, busy, expired;
    logic        unused_ir;

    assign unused_ir = ^ir[10:0];
    assign start     = !rst && state_q == MA_IDLE && t2 && is_memop(ir[15:11]);
    assign busy      = state_q == MA_LO || state_q == MA_HI;

    mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (!busy || bus.mem_rdy),
        .en      (busy && !bus.mem_rdy),
        .expired (expired)
    );

    assign bus.mem_req  = busy;
    assign bus.mem_rd   = busy && is_ld_q;
    assign bus.mem_wr   = busy && !is_ld_q;
    assign bus.mem_addr = state_q == MA_LO ? base_q : state_q == MA_HI ? base_q + 16'd1 : '0;
    assign bus.mem_dout = state_q == MA_LO ? st_q[7:0] : state_q == MA_HI ? st_q[15:8] : '0;
    assign stall        = start || busy;
    assign done         = state_q == MA_DONE;
    assign err          = done && to_q;
    assign mdr          = mdr_q;

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        st_d    = st_q;
        is_ld_d = is_ld_q;
        lo_d    = lo_q;
        mdr_d   = mdr_q;
        to_d    = to_q;
        case (state_q)
            MA_IDLE: if (start) begin
                state_d = MA_LO;
                base_d  = alu_out;
                st_d    = rb_data;
                is_ld_d = ir[15:11] == OP_LD;
                to_d    = 1'b0;
            end
            MA_LO: if (bus.mem_rdy) begin
                state_d = MA_HI;
                lo_d    = is_ld_q ? bus.mem_din : lo_q;
            end else if (expired) begin
                state_d = MA_DONE;
                to_d    = 1'b1;
            end
            MA_HI: if (bus.mem_rdy) begin
                state_d = MA_DONE;
                mdr_d   = is_ld_q ? {bus.mem_din, lo_q} : mdr_q;
            end else if (expired) begin
                state_d = MA_DONE;
                to_d    = 1'b1;
            end
            default: state_d = MA_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= MA_IDLE;
            base_q  <= '0;
            st_q    <= '0;
            is_ld_q <= 1'b0;
            lo_q    <= '0;
            mdr_q   <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            st_q    <= st_d;
            is_ld_q <= is_ld_d;
            lo_q    <= lo_d;
            mdr_q   <= mdr_d;
            to_q    <= to_d;
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: directed LD/ST scenarios against a byte memory model with beat/result scoreboards.
module tb_mem_access;
    import cpu_pkg::*;

    localparam int TO = 15;

    typedef struct packed {logic wr; logic [15:0] addr; logic [7:0] data;} beat_t;
    typedef struct packed {logic err; logic [15:0] mdr;} res_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        t2 = 1'b0;
    logic [15:0] ir = '0, alu_out = '0, rb_data = '0;
    logic [15:0] mdr;
    logic        stall, done, err;

    mem_access_if bus();

    mem_access #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .t2(t2), .ir(ir), .alu_out(alu_out), .rb_data(rb_data),
        .bus(bus), .mdr(mdr), .stall(stall), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [0:65535];
    int   wait_n = 0;
    logic hang = 1'b0;
    int   wcnt = 0;

    assign bus.mem_rdy = bus.mem_req && !hang && wcnt >= wait_n;
    assign bus.mem_din = mem[bus.mem_addr];

    always @(posedge clk) wcnt <= (bus.mem_req && !bus.mem_rdy) ? wcnt + 1 : 0;

    int checks = 0, errors = 0;
    beat_t beat_q[$];
    res_t  res_q[$];
    beat_t b;
    res_t  r;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Accepted beats and done pulses are matched against what each step queued
    always @(negedge clk) begin
        if (bus.mem_req && bus.mem_rdy) begin
            if (beat_q.size() == 0) chk("unexpected_beat", 1, 0);
            else begin
                b = beat_q.pop_front();
                chk("beat_wr", bus.mem_wr, b.wr);
                chk("beat_rd", bus.mem_rd, !b.wr);
                chk("beat_addr", bus.mem_addr, b.addr);
                if (b.wr) begin
                    chk("beat_data", bus.mem_dout, b.data);
                    mem[bus.mem_addr] <= bus.mem_dout;
                end
            end
        end
        if (done) begin
            if (res_q.size() == 0) chk("unexpected_done", 1, 0);
            else begin
                r = res_q.pop_front();
                chk("mdr", mdr, r.mdr);
                chk("err", err, r.err);
                chk("done_bus_idle", {bus.mem_req, bus.mem_rd, bus.mem_wr, stall}, 0);
            end
        end else chk("err_without_done", err, 0);
    end

    task automatic op(input logic [4:0] opc, input logic [15:0] a, input logic [15:0] d,
                      output int n, output int sc);
        @(negedge clk);
        ir = {opc, 11'h2A5};
        alu_out = a;
        rb_data = d;
        t2 = 1'b1;
        #1 chk("stall_start", stall, 1);
        @(negedge clk);
        t2 = 1'b0;
        ir = '0;
        alu_out = 16'hDEAD;
        rb_data = 16'h5555;
        #1;
        n = 1;
        sc = 1;
        while (1) begin
            sc += int'(stall);
            if (done || n >= 40) break;
            @(negedge clk);
            n++;
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk(tag, {bus.mem_req, bus.mem_rd, bus.mem_wr, stall, done, err}, 0);
        chk({tag, "_addr"}, bus.mem_addr, 0);
        chk({tag, "_dout"}, bus.mem_dout, 0);
    endtask

    initial begin
        int n, sc;
        logic [4:0] wb_ops [3];
        wb_ops = '{5'b00110, 5'b00100, 5'b10010};
        repeat (2) @(negedge clk);
        chk_idle_outputs("reset");
        chk("reset_mdr", mdr, 0);
        rst = 1'b0;
        // Load, zero wait
        mem[16'h1000] = 8'h34;
        mem[16'h1001] = 8'h12;
        beat_q.push_back('{1'b0, 16'h1000, 8'h00});
        beat_q.push_back('{1'b0, 16'h1001, 8'h00});
        res_q.push_back('{1'b0, 16'h1234});
        op(OP_LD, 16'h1000, 16'h0000, n, sc);
        chk("ld_latency", n, 3);
        chk("ld_stall_cycles", sc, 3);
        // Store, two wait states per beat
        wait_n = 2;
        beat_q.push_back('{1'b1, 16'h4000, 8'hEF});
        beat_q.push_back('{1'b1, 16'h4001, 8'hBE});
        res_q.push_back('{1'b0, 16'h1234});
        op(OP_ST, 16'h4000, 16'hBEEF, n, sc);
        chk("st_latency", n, 7);
        chk("st_stall_cycles", sc, 7);
        chk("st_mem_lo", mem[16'h4000], 8'hEF);
        chk("st_mem_hi", mem[16'h4001], 8'hBE);
        wait_n = 0;
        // Address wrap
        mem[16'hFFFF] = 8'hAB;
        mem[16'h0000] = 8'hCD;
        beat_q.push_back('{1'b0, 16'hFFFF, 8'h00});
        beat_q.push_back('{1'b0, 16'h0000, 8'h00});
        res_q.push_back('{1'b0, 16'hCDAB});
        op(OP_LD, 16'hFFFF, 16'h0000, n, sc);
        chk("wrap_latency", n, 3);
        // Timeout in LO
        hang = 1'b1;
        res_q.push_back('{1'b1, 16'hCDAB});
        op(OP_LD, 16'h2000, 16'h0000, n, sc);
        chk("to_latency", n, TO + 1);
        chk("to_stall_cycles", sc, TO + 1);
        @(negedge clk);
        hang = 1'b0;
        // Recovery load
        mem[16'h2000] = 8'h78;
        mem[16'h2001] = 8'h56;
        beat_q.push_back('{1'b0, 16'h2000, 8'h00});
        beat_q.push_back('{1'b0, 16'h2001, 8'h00});
        res_q.push_back('{1'b0, 16'h5678});
        op(OP_LD, 16'h2000, 16'h0000, n, sc);
        chk("recover_latency", n, 3);
        // Non-memory opcodes
        foreach (wb_ops[i]) begin
            @(negedge clk);
            ir = {wb_ops[i], 11'h0F0};
            t2 = 1'b1;
            #1 chk("nonmem_stall", stall, 0);
            repeat (2) begin
                @(negedge clk);
                chk_idle_outputs("nonmem_idle");
            end
            t2 = 1'b0;
        end
        // Reset while in HI
        mem[16'h3000] = 8'h11;
        mem[16'h3001] = 8'h22;
        beat_q.push_back('{1'b0, 16'h3000, 8'h00});
        beat_q.push_back('{1'b0, 16'h3001, 8'h00});
        @(negedge clk);
        ir = {OP_LD, 11'h000};
        alu_out = 16'h3000;
        t2 = 1'b1;
        @(negedge clk);
        t2 = 1'b0;
        @(negedge clk);
        chk("hi_addr", bus.mem_addr, 16'h3001);
        rst = 1'b1;
        @(negedge clk);
        chk_idle_outputs("rst_hi");
        chk("rst_hi_mdr", mdr, 0);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("rst_no_done", done, 0);
        end
        chk("beat_q_empty", beat_q.size(), 0);
        chk("res_q_empty", res_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
